// File: rtl/instr_mem_pkg.sv
// Shared constants and types for the instruction store.
// Imported by the RAM and the load/fetch wrapper.
package instr_mem_pkg;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // MIPS instructions are word aligned: byte PC >> 2 gives the word index.
    localparam int unsigned WORD_SHIFT = 2;

    localparam int unsigned IDX_MAX_W = 32;

    typedef logic [IDX_MAX_W-1:0] word_idx_t;

endpackage

// File: rtl/instr_ram.sv
// Plain DEPTH x DATA_W storage: one synchronous write port and one
// synchronous read port with read enable. No reset on the array.
module instr_ram
    import instr_mem_pkg::*;
#(
    parameter  int unsigned DATA_W = 32,
    parameter  int unsigned DEPTH  = 64,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_load_mem.sv
// Instruction store: serial load sessions plus registered PC fetch,
// with load count, overflow, past-end and misalignment flags.
module instr_load_mem
    import instr_mem_pkg::*;
#(
    parameter  int unsigned       DATA_W   = 32,
    parameter  int unsigned       DEPTH    = 64,
    parameter  int unsigned       PC_W     = 32,
    parameter  logic [DATA_W-1:0] NOP_WORD = DATA_W'(instr_mem_pkg::NOP_WORD),
    localparam int unsigned       ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              Reset_n,
    input  logic              LoadInstructions,
    input  logic [DATA_W-1:0] Instruction,
    input  logic              prog_clear,
    input  logic              fetch_en,
    input  logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] instr_out,
    output logic              instr_valid,
    output logic              past_end,
    output logic              misaligned,
    output logic [ADDR_W:0]   load_count,
    output logic              load_overflow
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic              load_prev_q;
    logic [ADDR_W:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              valid_q, past_q, mis_q;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] rdata;

    logic              start;
    logic [ADDR_W-1:0] idx;
    logic              hi;
    logic              mis_c, past_c, ok_c;

    assign start = LoadInstructions & ~load_prev_q;

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        we      = 1'b0;
        waddr   = '0;
        if (prog_clear) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (start) begin
            we      = 1'b1;
            count_d = (ADDR_W+1)'(1);
            ovf_d   = 1'b0;
        end else if (LoadInstructions) begin
            if (count_q < DEPTH_C) begin
                we      = 1'b1;
                waddr   = count_q[ADDR_W-1:0];
                count_d = count_q + 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    assign idx    = pc[ADDR_W+WORD_SHIFT-1:WORD_SHIFT];
    assign hi     = (pc >> (ADDR_W + WORD_SHIFT)) != '0;
    assign mis_c  = pc[WORD_SHIFT-1:0] != '0;
    assign past_c = hi | (word_idx_t'(idx) >= word_idx_t'(count_q));
    assign ok_c   = ~mis_c & ~past_c & ~LoadInstructions;

    // The array and the count survive reset so a loaded program can run
    // after a CPU reset; a write in a reset cycle still lands.
    always_ff @(posedge clk) begin
        count_q <= count_d;
        if (!Reset_n) begin
            load_prev_q <= 1'b0;
            ovf_q       <= 1'b0;
            valid_q     <= 1'b0;
            past_q      <= 1'b0;
            mis_q       <= 1'b0;
        end else begin
            load_prev_q <= LoadInstructions;
            ovf_q       <= ovf_d;
            if (fetch_en) begin
                valid_q <= ok_c;
                past_q  <= past_c;
                mis_q   <= mis_c;
            end
        end
    end

    instr_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (Instruction),
        .re_i    (fetch_en),
        .raddr_i (idx),
        .rdata_o (rdata)
    );

    // RAM data is held with the read enable, so gating by valid gives NOP
    // for every rejected fetch and after reset.
    assign instr_out     = valid_q ? rdata : NOP_WORD;
    assign instr_valid   = valid_q;
    assign past_end      = past_q;
    assign misaligned    = mis_q;
    assign load_count    = count_q;
    assign load_overflow = ovf_q;

endmodule

// File: doc/instr_load_mem.md
Name: instr_load_mem

Overview:
- Parametrised instruction store for the single-cycle/pipelined MIPS CPU.
- Replaces the fixed inline loader: words stream in serially while LoadInstructions is high, and are then fetched by PC with a registered read.
- Adds depth/width parameters, load count, overflow detection, end-of-program and misalignment detection.
- Sits between the bench/boot source and the CPU fetch stage.

Parameters:
- DATA_W, 32, instruction width in bits.
- DEPTH, 64, number of instruction words; power of two, at least 2.
- ADDR_W, $clog2(DEPTH), word index width (derived, not overridden).
- PC_W, 32, width of the byte-addressed PC.
- NOP_WORD, 32'h0000_0000, word returned for any invalid fetch.

Ports:
- clk  in  1  rising-edge clock.
- Reset_n  in  1  synchronous, active-low reset.
- LoadInstructions  in  1  high = load session active; one word written per cycle.
- Instruction  in  DATA_W  word to write during a load session.
- prog_clear  in  1  synchronous clear of the program region (load_count := 0).
- fetch_en  in  1  request a fetch at pc this cycle.
- pc  in  PC_W  byte address of the fetch.
- instr_out  out  DATA_W  fetched word, registered.
- instr_valid  out  1  instr_out holds a loaded word.
- past_end  out  1  the last fetch addressed index >= load_count.
- misaligned  out  1  the last fetch had pc[1:0] != 0.
- load_count  out  ADDR_W+1  number of words loaded in the current program.
- load_overflow  out  1  sticky: a write was attempted with load_count == DEPTH.

Behaviour:
- Reset (Reset_n = 0 at the clock edge):
  - instr_out := NOP_WORD; instr_valid, past_end, misaligned := 0.
  - load_overflow := 0; load_prev := 0.
  - Memory and load_count are NOT cleared, so a program survives a CPU reset (flow: load, reset, run).
- Power-up: load_count is undefined until the first load-session start or prog_clear. Benches must issue one before fetching.
- prog_clear: load_count := 0 and load_overflow := 0 next cycle. It has priority over a load write in the same cycle, and that write is dropped.
- Load-session start: the cycle where LoadInstructions = 1 and load_prev = 0.
  - Writes Instruction to index 0.
  - load_count := 1; load_overflow := 0.
- Continuing session (LoadInstructions = 1, load_prev = 1):
  - If load_count < DEPTH: write mem[load_count]; load_count += 1.
  - Otherwise: the write is dropped, load_count holds, load_overflow := 1.
- load_prev is registered from LoadInstructions every cycle.
- Fetch (1-cycle latency; outputs update at the edge after fetch_en):
  - idx = pc[ADDR_W+1:2]; hi = (pc >> (ADDR_W+2)) != 0.
  - misaligned := (pc[1:0] != 0).
  - past_end := hi or (idx >= load_count).
  - ok := ~misaligned & ~past_end & ~LoadInstructions.
  - instr_out := ok ? mem[idx] : NOP_WORD; instr_valid := ok.
- fetch_en = 0: instr_out, instr_valid, past_end and misaligned hold their values.
- Fetch during an active load: returns NOP with instr_valid = 0. past_end and misaligned are still computed. There is no read-during-write forwarding.
- Reset_n = 0 mid-load: the write in that cycle is still performed. load_prev := 0, so if LoadInstructions stays high after reset, a new session starts and restarts at index 0.
- Reset_n = 0 with fetch_en = 1: reset wins; outputs take their reset values.
- load_count saturates at DEPTH and never wraps.

Decomposition:
- Package instr_mem_pkg holds:
  - the NOP_WORD constant;
  - localparams for the MIPS word alignment shift (2);
  - a typedef for the word-index type.
- Sub-module instr_ram: DEPTH x DATA_W, one synchronous write port and one synchronous read port, no reset.
- instr_load_mem holds the session, count and flag logic around instr_ram.

Test Plan:
- Load and fetch: reset, load the 16-word discussion program (first word 0x200101A7 = addi R1,R0,423), then Reset_n = 0 for 1 cycle. Require load_count = 16 after the reset. Fetch pc = 0x0 and require instr_out = 0x200101A7, instr_valid = 1 on the next cycle. Fetch pc = 0x3C and require the last word (add R7,R8,R3).
- Past end: with the same program, fetch pc = 0x40 → instr_out = 0, instr_valid = 0, past_end = 1. Fetch pc = 0x100 (beyond DEPTH*4) → past_end = 1.
- Misaligned: fetch pc = 0x6 → misaligned = 1, instr_valid = 0, instr_out = 0.
- Overflow: DEPTH = 4; load 6 words 0xA..0xF → load_count = 4, load_overflow = 1. Fetch at 0xC returns 0xD. Start a new session → load_overflow clears and load_count = 1.
- Reload: load 3 words, drop LoadInstructions, load 2 new words 0x11 and 0x22 → load_count = 2. Fetch 0x0 returns 0x11. Fetch 0x8 → past_end = 1 (the old word is not visible).
- Conflicts:
  - fetch_en = 1 during a load → instr_valid = 0.
  - prog_clear together with a load write → load_count = 0 and the write is dropped.
  - Reset_n = 0 during fetch_en → instr_out = 0, instr_valid = 0.
